// File: rtl/vram_pkg.sv
// Shared constants and types for the two-plane frame buffer and its blitter.
// Pure declarations: no logic, no latency, no flow control.
package vram_pkg;
    localparam int W_MAX = 128;
    localparam int H_MAX = 64;
    localparam int LO_W  = 64;
    localparam int LO_H  = 32;

    localparam logic OP_CLEAR = 1'b0;
    localparam logic OP_DRAW  = 1'b1;

    typedef logic [W_MAX-1:0] row_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_DRAW_ROW,
        ST_DONE
    } state_t;
endpackage

// File: rtl/vram_planes.sv
// Two 1-bit pixel planes: whole-row writes on clk, combinational row and pixel reads.
// Reads see the pre-edge contents; no stalls on either side.
module vram_planes
    import vram_pkg::*;
(
    input  logic       clk,
    input  logic [1:0] wr_en_i,
    input  logic [5:0] wr_row_i,
    input  row_t       wr_dat_i,
    input  logic [5:0] rr_row_i,
    output row_t       rr_dat0_o,
    output row_t       rr_dat1_o,
    input  logic [6:0] rd_hpos_i,
    input  logic [5:0] rd_vpos_i,
    output logic [1:0] rd_pixel_o
);
    row_t plane0_q [H_MAX];
    row_t plane1_q [H_MAX];

    always_ff @(posedge clk) begin
        if (wr_en_i[0]) plane0_q[wr_row_i] <= wr_dat_i;
        if (wr_en_i[1]) plane1_q[wr_row_i] <= wr_dat_i;
    end

    assign rr_dat0_o  = plane0_q[rr_row_i];
    assign rr_dat1_o  = plane1_q[rr_row_i];
    assign rd_pixel_o = {plane1_q[rd_vpos_i][rd_hpos_i], plane0_q[rd_vpos_i][rd_hpos_i]};
endmodule

// File: rtl/vram_blit.sv
// CLEAR / XOR sprite DRAW engine over vram_planes; CLEAR takes H cycles, DRAW one cycle per byte.
// cmd_ready only in IDLE, spr_ready only in DRAW_ROW; vdrive pixel reads never stall.
module vram_blit
    import vram_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       hires,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_op,
    input  logic [1:0] cmd_planes,
    input  logic [6:0] cmd_x,
    input  logic [5:0] cmd_y,
    input  logic [3:0] cmd_n,
    input  logic       spr_valid,
    output logic       spr_ready,
    input  logic [7:0] spr_data,
    output logic       done,
    output logic       collision,
    input  logic [6:0] vram_hpos,
    input  logic [5:0] vram_vpos,
    output logic [1:0] vram_pixel
);
    state_t     state_q, state_d;
    logic [1:0] planes_q, planes_d;
    logic       hires_q, hires_d;
    logic [6:0] x0_q, x0_d;
    logic [5:0] y0_q, y0_d;
    logic [3:0] n_q, n_d;
    logic [5:0] row_q, row_d;
    logic       byte_q, byte_d;
    logic       plane_q, plane_d;
    logic       coll_q, coll_d;

    logic       accept, spr_hs, wide, last_byte, last_row, last_clear_row, row_ok;
    logic [6:0] draw_row;
    logic [7:0] col_base;
    logic [7:0] spr_rev;
    row_t       col_mask, upd, old_row, rr0, rr1;
    logic [1:0] wr_en;
    logic [5:0] wr_row;
    row_t       wr_dat;

    assign cmd_ready = (state_q == ST_IDLE);
    assign spr_ready = (state_q == ST_DRAW_ROW);
    assign done      = (state_q == ST_DONE);
    assign collision = coll_q;

    assign accept = cmd_valid & cmd_ready;
    assign spr_hs = spr_valid & spr_ready;

    // cmd_n == 0 selects the 16x16 sprite: two bytes per row, sixteen rows
    assign wide           = (n_q == 4'd0);
    assign last_byte      = !wide || byte_q;
    assign last_row       = wide ? (row_q == 6'd15) : (row_q == {2'b00, n_q - 4'd1});
    assign last_clear_row = (row_q == (hires_q ? 6'(H_MAX - 1) : 6'(LO_H - 1)));

    // Target row/column can run past the screen edge; those pixels are clipped, not wrapped
    assign draw_row = {1'b0, y0_q} + {1'b0, row_q};
    assign row_ok   = draw_row < (hires_q ? 7'(H_MAX) : 7'(LO_H));
    assign col_base = {1'b0, x0_q} + {4'd0, byte_q, 3'd0};
    assign col_mask = hires_q ? {W_MAX{1'b1}} : {{(W_MAX - LO_W){1'b0}}, {LO_W{1'b1}}};

    always_comb begin
        spr_rev = '0;
        for (int k = 0; k < 8; k++) spr_rev[k] = spr_data[7-k];
    end

    assign upd     = ({{(W_MAX - 8){1'b0}}, spr_rev} << col_base) & col_mask & {W_MAX{row_ok}};
    assign old_row = plane_q ? rr1 : rr0;

    always_comb begin
        wr_en  = 2'b00;
        wr_row = row_q;
        wr_dat = old_row ^ upd;
        if (state_q == ST_CLEAR) begin
            wr_en  = planes_q;
            wr_dat = '0;
        end else if (state_q == ST_DRAW_ROW && spr_hs && row_ok) begin
            wr_en  = plane_q ? 2'b10 : 2'b01;
            wr_row = draw_row[5:0];
        end
    end

    vram_planes u_planes (
        .clk        (clk),
        .wr_en_i    (wr_en),
        .wr_row_i   (wr_row),
        .wr_dat_i   (wr_dat),
        .rr_row_i   (draw_row[5:0]),
        .rr_dat0_o  (rr0),
        .rr_dat1_o  (rr1),
        .rd_hpos_i  (vram_hpos),
        .rd_vpos_i  (vram_vpos),
        .rd_pixel_o (vram_pixel)
    );

    always_comb begin
        state_d  = state_q;
        planes_d = planes_q;
        hires_d  = hires_q;
        x0_d     = x0_q;
        y0_d     = y0_q;
        n_d      = n_q;
        row_d    = row_q;
        byte_d   = byte_q;
        plane_d  = plane_q;
        coll_d   = coll_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    planes_d = cmd_planes;
                    hires_d  = hires;
                    x0_d     = hires ? cmd_x : {1'b0, cmd_x[5:0]};
                    y0_d     = hires ? cmd_y : {1'b0, cmd_y[4:0]};
                    n_d      = cmd_n;
                    row_d    = 6'd0;
                    byte_d   = 1'b0;
                    plane_d  = !cmd_planes[0];
                    coll_d   = 1'b0;
                    if (cmd_op == OP_CLEAR)        state_d = ST_CLEAR;
                    else if (cmd_planes == 2'b00)  state_d = ST_DONE;
                    else                           state_d = ST_DRAW_ROW;
                end
            end
            ST_CLEAR: begin
                row_d = row_q + 6'd1;
                if (last_clear_row) state_d = ST_DONE;
            end
            ST_DRAW_ROW: begin
                if (spr_hs) begin
                    if (|(old_row & upd)) coll_d = 1'b1;
                    if (!last_byte) begin
                        byte_d = 1'b1;
                    end else begin
                        byte_d = 1'b0;
                        if (!last_row) begin
                            row_d = row_q + 6'd1;
                        end else begin
                            row_d = 6'd0;
                            if (!plane_q && planes_q[1]) plane_d = 1'b1;
                            else                         state_d = ST_DONE;
                        end
                    end
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            planes_q <= 2'b00;
            hires_q  <= 1'b0;
            x0_q     <= 7'd0;
            y0_q     <= 6'd0;
            n_q      <= 4'd0;
            row_q    <= 6'd0;
            byte_q   <= 1'b0;
            plane_q  <= 1'b0;
            coll_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            planes_q <= planes_d;
            hires_q  <= hires_d;
            x0_q     <= x0_d;
            y0_q     <= y0_d;
            n_q      <= n_d;
            row_q    <= row_d;
            byte_q   <= byte_d;
            plane_q  <= plane_d;
            coll_q   <= coll_d;
        end
    end
endmodule
